// File: rtl/nvdla_csb_arbiter_pkg.sv
// Shared CSB types and helpers for the CSB arbiter and its tag FIFO.
package nvdla_csb_arbiter_pkg;

    localparam int CSB_ADDR_W = 16;
    localparam int CSB_DATA_W = 32;

    typedef struct packed {
        logic [CSB_ADDR_W-1:0] addr;
        logic [CSB_DATA_W-1:0] wdata;
        logic                  write;
        logic                  nposted;
    } csb_req_t;

    typedef struct packed {
        logic [CSB_DATA_W-1:0] data;
        logic                  is_write;
    } csb_resp_t;

    // Reads and non-posted writes produce a response and therefore need a tag.
    function automatic logic is_tracked(input logic write, input logic nposted);
        return (!write) || nposted;
    endfunction

endpackage

// File: rtl/nvdla_csb_arbiter_tag_fifo.sv
// In-order FIFO of requester tags for transactions still awaiting a CSB response.
module nvdla_csb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         tag_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        do_push_s, do_pop_s;

    // Status flags and head tag come straight from the registered state.
    always_comb begin
        full_o  = (cnt_q == CNT_W'(DEPTH));
        empty_o = (cnt_q == '0);
        count_o = cnt_q;
        head_o  = mem_q[rd_q];
    end

    // Next-state: guarded push/pop; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        mem_d     = mem_q;
        if (do_push_s) begin
            mem_d[wr_q] = tag_i;
            wr_d        = wr_q + PTR_W'(1'b1);
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = rd_q + PTR_W'(1'b1);
        end else begin
            rd_d = rd_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nvdla_csb_arbiter.sv
// Round-robin arbiter sharing one CSB request/response channel between N_REQ requesters;
// responses are routed back in order through a tag FIFO.
module nvdla_csb_arbiter
    import nvdla_csb_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = CSB_ADDR_W,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    output logic [N_REQ-1:0]               req_ready_o,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ-1:0][31:0]         req_wdata_i,
    input  logic [N_REQ-1:0]               req_write_i,
    input  logic [N_REQ-1:0]               req_nposted_i,
    output logic [N_REQ-1:0]               resp_valid_o,
    output logic [31:0]                    resp_data_o,
    output logic                           resp_is_write_o,
    output logic                           csb_req_valid_o,
    input  logic                           csb_req_ready_i,
    output logic [ADDR_W-1:0]              csb_req_addr_o,
    output logic [31:0]                    csb_req_wdata_o,
    output logic                           csb_req_write_o,
    output logic                           csb_req_nposted_o,
    input  logic                           csb_resp_valid_i,
    input  logic [31:0]                    csb_resp_data_i,
    input  logic                           csb_resp_is_write_i,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic [TAG_W-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, gnt_idx_s, fifo_head_s;
    logic             lock_q, lock_d, gnt_valid_s, hs_s, push_s, pop_s;
    logic             fifo_full_s, fifo_empty_s, err_q, err_d, busy_q, busy_d;
    logic [CNT_W-1:0] fifo_count_s;
    logic [N_REQ-1:0] elig_s, resp_valid_q, resp_valid_d;
    csb_resp_t        resp_q, resp_d;

    function automatic logic [TAG_W:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [TAG_W-1:0] ptr);
        logic [TAG_W:0]   pick;
        logic [TAG_W-1:0] idx;
        pick = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = TAG_W'((int'(ptr) + k) % N_REQ);
            if (!pick[TAG_W] && elig[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [TAG_W-1:0] next_idx(input logic [TAG_W-1:0] g);
        return (g == TAG_W'(N_REQ - 1)) ? '0 : g + TAG_W'(1'b1);
    endfunction

    // A full FIFO blocks tracked requests even when a response pops in the same cycle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig_s[i] = req_valid_i[i] &&
                        (!is_tracked(req_write_i[i], req_nposted_i[i]) || !fifo_full_s);
        end
    end

    // Grant: held while locked, otherwise first eligible from the RR pointer.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_idx_s   = rr_q;
        if (lock_q) begin
            gnt_valid_s = req_valid_i[lock_idx_q];
            gnt_idx_s   = lock_idx_q;
        end else begin
            {gnt_valid_s, gnt_idx_s} = rr_pick(elig_s, rr_q);
        end
    end

    // Next-state for pointer, lock, FIFO strobes, error and response registers.
    always_comb begin
        hs_s       = gnt_valid_s && csb_req_ready_i;
        push_s     = hs_s && is_tracked(req_write_i[gnt_idx_s], req_nposted_i[gnt_idx_s]);
        pop_s      = csb_resp_valid_i && !fifo_empty_s;
        rr_d       = hs_s ? next_idx(gnt_idx_s) : rr_q;
        lock_d     = gnt_valid_s && !csb_req_ready_i;
        lock_idx_d = gnt_idx_s;
        err_d      = err_q || (csb_resp_valid_i && fifo_empty_s) ||
                     (lock_q && !req_valid_i[lock_idx_q]);
        busy_d     = (fifo_count_s != '0);
        if (pop_s) begin
            resp_valid_d  = N_REQ'(1'b1) << fifo_head_s;
            resp_d.data     = csb_resp_data_i;
            resp_d.is_write = csb_resp_is_write_i;
        end else begin
            resp_valid_d    = '0;
            resp_d.data     = 32'h0;
            resp_d.is_write = 1'b0;
        end
    end

    // Downstream request mux and per-requester ready.
    always_comb begin
        if (gnt_valid_s) begin
            req_ready_o       = (N_REQ'(1'b1) << gnt_idx_s) & {N_REQ{csb_req_ready_i}};
            csb_req_valid_o   = 1'b1;
            csb_req_addr_o    = req_addr_i[gnt_idx_s];
            csb_req_wdata_o   = req_wdata_i[gnt_idx_s];
            csb_req_write_o   = req_write_i[gnt_idx_s];
            csb_req_nposted_o = req_nposted_i[gnt_idx_s];
        end else begin
            req_ready_o       = '0;
            csb_req_valid_o   = 1'b0;
            csb_req_addr_o    = '0;
            csb_req_wdata_o   = 32'h0;
            csb_req_write_o   = 1'b0;
            csb_req_nposted_o = 1'b0;
        end
    end

    nvdla_csb_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .tag_i   (gnt_idx_s),
        .pop_i   (pop_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s),
        .head_o  (fifo_head_s)
    );

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q         <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= '0;
            resp_q       <= '0;
        end else begin
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = resp_q.data;
    assign resp_is_write_o = resp_q.is_write;
    assign busy_o          = busy_q;
    assign err_o           = err_q;

endmodule
